// File: rtl/mdu_if.sv
// mdu_if: handshake/result bundle between E-stage decode and the mdu.
//   start  1  one-cycle qualifier for op/a/b
//   op     4  operation code
//   a, b   32 forwarded rs/rt operands
//   busy   1  long operation in flight (registered)
//   hi, lo 32 architectural HI/LO
// master: E-stage decode side; slave: the mdu.
interface mdu_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the HI/LO register pair.
// The result of a long op is computed at the start edge into phi/plo and
// committed to hi/lo after a fixed latency; busy covers that latency.
//
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high; clears all state
//   bus    mdu_if.slave (start/op/a/b in, busy/hi/lo out)
// Parameters:
//   MULT_CYCLES  busy duration of MULT/MULTU (and MADD-family)
//   DIV_CYCLES   busy duration of DIV/DIVU
// Build option:
//   MDU_MADD_EN  enables op codes 6-9 (MADD/MADDU/MSUB/MSUBU); when undefined
//                they are reserved and no accumulate datapath exists.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | accepting start; MTHI/MTLO write directly
// RUN   | long op in flight, cnt counts down; commit phi/plo at cnt==0
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_load;
  logic [31:0]      hi_q, lo_q, phi_q, plo_q;
  logic [31:0]      res_hi, res_lo;
  logic             is_long, is_div;
  logic             busy, commit, long_start, mthi_we, mtlo_we;

  // ---------------- op decode ----------------
  always_comb begin
    is_long = 1'b0;
    is_div  = 1'b0;
    case (bus.op)
      OP_MULT, OP_MULTU: is_long = 1'b1;
      OP_DIV, OP_DIVU: begin
        is_long = 1'b1;
        is_div  = 1'b1;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_long = 1'b1;
`endif
      default: ;
    endcase
  end

  assign cnt_load = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

  // ---------------- datapath ----------------
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
  assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};

  // One unsigned divider serves both DIV and DIVU: signed division works on
  // magnitudes and fixes signs afterwards, which also yields the required
  // 0x80000000 / -1 = 0x80000000 without overflow trouble.
  logic        sgn;
  logic [31:0] num, den, quo, rem;
  assign sgn = (bus.op == OP_DIV);
  assign num = (sgn && bus.a[31]) ? -bus.a : bus.a;
  assign den = (bus.b == 32'd0) ? 32'd1 : ((sgn && bus.b[31]) ? -bus.b : bus.b);
  assign quo = num / den;
  assign rem = num % den;

  // Default keeps current hi/lo, so a divide by zero commits the same values.
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (bus.op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: if (bus.b != 32'd0) begin
        res_lo = (bus.a[31] ^ bus.b[31]) ? -quo : quo;
        res_hi = bus.a[31] ? -rem : rem;
      end
      OP_DIVU: if (bus.b != 32'd0) begin
        res_lo = quo;
        res_hi = rem;
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
      OP_MADDU: {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
      OP_MSUB:  {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
      OP_MSUBU: {res_hi, res_lo} = {hi_q, lo_q} - prod_u;
`endif
      default: ;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start && is_long) state_d = RUN;
      RUN:  if (cnt_q == '0)          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == RUN);
    commit     = (state_q == RUN) && (cnt_q == '0);
    long_start = (state_q == IDLE) && bus.start && is_long;
    mthi_we    = (state_q == IDLE) && bus.start && (bus.op == OP_MTHI);
    mtlo_we    = (state_q == IDLE) && bus.start && (bus.op == OP_MTLO);
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      phi_q <= '0;
      plo_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      if (long_start) begin
        phi_q <= res_hi;
        plo_q <= res_lo;
        cnt_q <= cnt_load;
      end else if (busy && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (commit) begin
        hi_q <= phi_q;
        lo_q <= plo_q;
      end else begin
        if (mthi_we) hi_q <= bus.a;
        if (mtlo_we) lo_q <= bus.a;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
`ifdef MDU_MADD_EN
  localparam int OP_MAX = 9;
`else
  localparam int OP_MAX = 5;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if u_if ();

  mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mhi, mlo;

  // Reference model: architectural effect of one accepted op on HI/LO,
  // using 64-bit integer arithmetic; returns the expected busy length.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int lat);
    longint sa, sb;
    logic [63:0] p, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lat = 0;
    case (op)
      4'd0: begin p = 64'(sa * sb); {mhi, mlo} = p; lat = MULT_CYCLES; end
      4'd1: begin p = 64'(a) * 64'(b); {mhi, mlo} = p; lat = MULT_CYCLES; end
      4'd2: begin
        lat = DIV_CYCLES;
        if (b != 0) begin mlo = 32'(sa / sb); mhi = 32'(sa % sb); end
      end
      4'd3: begin
        lat = DIV_CYCLES;
        if (b != 0) begin mlo = a / b; mhi = a % b; end
      end
      4'd4: mhi = a;
      4'd5: mlo = a;
`ifdef MDU_MADD_EN
      4'd6, 4'd7, 4'd8, 4'd9: begin
        p   = (op == 4'd6 || op == 4'd8) ? 64'(sa * sb) : 64'(a) * 64'(b);
        acc = {mhi, mlo};
        acc = (op < 4'd8) ? acc + p : acc - p;
        {mhi, mlo} = acc;
        lat = MULT_CYCLES;
      end
`endif
      default: ;
    endcase
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.op    = op;
    u_if.a     = a;
    u_if.b     = b;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
  endtask

  // Counts cycles with busy high, starting just after the start edge.
  task automatic count_busy(output int n);
    n = 0;
    while (u_if.busy === 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    u_if.start = 1'b1; u_if.op = 4'd4; u_if.a = 32'h1234_5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    u_if.start = 1'b0;
    @(posedge clk); #1;
    mhi = 0; mlo = 0;
    checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", u_if.busy); end
    checks++; if (u_if.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", u_if.hi); end
    checks++; if (u_if.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", u_if.lo); end
  endtask

  task automatic test_mult;
    int lat, n;
    for (int i = 0; i < 2; i++) begin
      model_apply(4'(i), 32'hFFFF_FFFF, 32'd2, lat);
      issue(4'(i), 32'hFFFF_FFFF, 32'd2);
      count_busy(n);
      checks++; if (n != lat) begin errors++; $display("FAIL mult%0d_busy: got %0d want %0d", i, n, lat); end
      checks++; if (u_if.hi !== mhi) begin errors++; $display("FAIL mult%0d_hi: got %h want %h", i, u_if.hi, mhi); end
      checks++; if (u_if.lo !== mlo) begin errors++; $display("FAIL mult%0d_lo: got %h want %h", i, u_if.lo, mlo); end
    end
  endtask

  task automatic test_div;
    logic [3:0]  ops [4] = '{4'd2, 4'd3, 4'd2, 4'd2};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd7};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    int lat, n;
    for (int i = 0; i < 4; i++) begin
      model_apply(ops[i], as[i], bs[i], lat);
      issue(ops[i], as[i], bs[i]);
      count_busy(n);
      checks++; if (n != lat) begin errors++; $display("FAIL div%0d_busy: got %0d want %0d", i, n, lat); end
      checks++; if (u_if.hi !== mhi) begin errors++; $display("FAIL div%0d_hi: got %h want %h", i, u_if.hi, mhi); end
      checks++; if (u_if.lo !== mlo) begin errors++; $display("FAIL div%0d_lo: got %h want %h", i, u_if.lo, mlo); end
    end
  endtask

  task automatic test_mt_divzero;
    int lat, n;
    model_apply(4'd4, 32'h11, 32'h0, lat);
    issue(4'd4, 32'h11, 32'h0);
    checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", u_if.busy); end
    checks++; if (u_if.hi !== mhi) begin errors++; $display("FAIL mthi_hi: got %h want %h", u_if.hi, mhi); end
    model_apply(4'd5, 32'h22, 32'h0, lat);
    issue(4'd5, 32'h22, 32'h0);
    checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b want 0", u_if.busy); end
    checks++; if (u_if.lo !== mlo) begin errors++; $display("FAIL mtlo_lo: got %h want %h", u_if.lo, mlo); end
    for (int i = 2; i < 4; i++) begin
      model_apply(4'(i), 32'hCAFE_0001, 32'h0, lat);
      issue(4'(i), 32'hCAFE_0001, 32'h0);
      count_busy(n);
      checks++; if (n != lat) begin errors++; $display("FAIL divzero%0d_busy: got %0d want %0d", i, n, lat); end
      checks++; if (u_if.hi !== mhi) begin errors++; $display("FAIL divzero%0d_hi: got %h want %h", i, u_if.hi, mhi); end
      checks++; if (u_if.lo !== mlo) begin errors++; $display("FAIL divzero%0d_lo: got %h want %h", i, u_if.lo, mlo); end
    end
  endtask

  task automatic test_start_in_run;
    int lat, n;
    model_apply(4'd0, 32'd3, 32'd4, lat);
    issue(4'd0, 32'd3, 32'd4);
    issue(4'd4, 32'hDEAD, 32'd0);
    issue(4'd2, 32'd100, 32'd7);
    count_busy(n);
    checks++; if (n != lat - 2) begin errors++; $display("FAIL inrun_busy: got %0d want %0d", n, lat - 2); end
    checks++; if (u_if.hi !== mhi) begin errors++; $display("FAIL inrun_hi: got %h want %h", u_if.hi, mhi); end
    checks++; if (u_if.lo !== mlo) begin errors++; $display("FAIL inrun_lo: got %h want %h", u_if.lo, mlo); end
  endtask

  task automatic test_reset_mid;
    issue(4'd0, 32'd3, 32'd4);
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    u_if.start = 1'b1; u_if.op = 4'd5; u_if.a = 32'h55;
    @(posedge clk); #1;
    reset = 1'b0;
    u_if.start = 1'b0;
    mhi = 0; mlo = 0;
    checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", u_if.busy); end
    checks++; if (u_if.hi !== mhi) begin errors++; $display("FAIL rstmid_hi: got %h want %h", u_if.hi, mhi); end
    checks++; if (u_if.lo !== mlo) begin errors++; $display("FAIL rstmid_lo: got %h want %h", u_if.lo, mlo); end
    repeat (MULT_CYCLES + 2) @(posedge clk);
    #1;
    checks++; if ({u_if.busy, u_if.hi, u_if.lo} !== {1'b0, mhi, mlo}) begin
      errors++; $display("FAIL rstmid_late: got busy=%b hi=%h lo=%h want 0/0/0", u_if.busy, u_if.hi, u_if.lo);
    end
  endtask

  task automatic test_madd;
    int lat, n;
`ifdef MDU_MADD_EN
    logic [3:0]  ops [3] = '{4'd5, 4'd6, 4'd9};
    logic [31:0] as  [3] = '{32'd10, 32'd3, 32'd5};
    logic [31:0] bs  [3] = '{32'd0, 32'd4, 32'd5};
    for (int i = 0; i < 3; i++) begin
      model_apply(ops[i], as[i], bs[i], lat);
      issue(ops[i], as[i], bs[i]);
      count_busy(n);
      checks++; if (n != lat) begin errors++; $display("FAIL madd%0d_busy: got %0d want %0d", i, n, lat); end
      checks++; if (u_if.hi !== mhi) begin errors++; $display("FAIL madd%0d_hi: got %h want %h", i, u_if.hi, mhi); end
      checks++; if (u_if.lo !== mlo) begin errors++; $display("FAIL madd%0d_lo: got %h want %h", i, u_if.lo, mlo); end
    end
`else
    for (int op = 6; op < 10; op++) begin
      model_apply(4'(op), 32'd3, 32'd4, lat);
      issue(4'(op), 32'd3, 32'd4);
      checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL madd_off%0d_busy: got %b want 0", op, u_if.busy); end
      repeat (MULT_CYCLES + 1) @(posedge clk);
      #1;
      count_busy(n);
      checks++; if (u_if.hi !== mhi || u_if.lo !== mlo) begin
        errors++; $display("FAIL madd_off%0d_hilo: got %h/%h want %h/%h", op, u_if.hi, u_if.lo, mhi, mlo);
      end
    end
`endif
  endtask

  task automatic test_reserved;
    int lat;
    for (int op = 10; op < 16; op++) begin
      model_apply(4'(op), $urandom, $urandom, lat);
      issue(4'(op), $urandom, $urandom);
      checks++; if (u_if.busy !== 1'b0 || u_if.hi !== mhi || u_if.lo !== mlo) begin
        errors++; $display("FAIL reserved%0d: got busy=%b hi=%h lo=%h want 0/%h/%h", op, u_if.busy, u_if.hi, u_if.lo, mhi, mlo);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat, n;
    logic [31:0] a, b;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom_range(1, 1000);
      model_apply((i == 1) ? 4'd3 : 4'd0, a, b, lat);
      issue((i == 1) ? 4'd3 : 4'd0, a, b);
      checks++; if (u_if.busy !== 1'b1) begin errors++; $display("FAIL b2b%0d_accept: got busy=%b want 1", i, u_if.busy); end
      count_busy(n);
      checks++; if (n != lat || u_if.hi !== mhi || u_if.lo !== mlo) begin
        errors++; $display("FAIL b2b%0d: got n=%0d hi=%h lo=%h want n=%0d hi=%h lo=%h", i, n, u_if.hi, u_if.lo, lat, mhi, mlo);
      end
    end
  endtask

  task automatic test_random;
    int lat, n;
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, OP_MAX));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      model_apply(op, a, b, lat);
      issue(op, a, b);
      count_busy(n);
      checks++; if (n != lat) begin errors++; $display("FAIL rnd%0d_busy: op=%0d got %0d want %0d", i, op, n, lat); end
      checks++; if (u_if.hi !== mhi || u_if.lo !== mlo) begin
        errors++; $display("FAIL rnd%0d_hilo: op=%0d a=%h b=%h got %h/%h want %h/%h", i, op, a, b, u_if.hi, u_if.lo, mhi, mlo);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    u_if.start = 1'b0;
    u_if.op    = 4'd0;
    u_if.a     = 32'd0;
    u_if.b     = 32'd0;
    mhi = 0; mlo = 0;
    test_reset;
    test_mult;
    test_div;
    test_mt_divzero;
    test_start_in_run;
    test_reset_mid;
    test_madd;
    test_reserved;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
